ddr_tree_serializer: RTL and testbench

- Parametrised WIDTH:1 double-data-rate serializer.
- Accepts a parallel word through a valid/ready handshake and buffers one further word, so back-to-back words stream without gaps.
- Emits two bits per CLK cycle on SERIAL_OUT: one while CLK is high, one while CLK is low.
- Successor to the fixed 2:1 latch-based DDR output stage. Sits at the chip output boundary, fed by the core-side word source.

---
 rtl/ddr_ser_pkg.sv | 29 ++
 rtl/ser_ddr_mux.sv | 21 ++
 rtl/ddr_tree_serializer.sv | 134 +++++++++++++
 tb/tb_ddr_tree_serializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_ser_pkg.sv
// ddr_ser_pkg
//   Shared definitions for the DDR word serializer:
//   - ser_state_e : serializer FSM states (IDLE, SHIFT)
//   - beats()     : cycles needed to emit one word (two bits per cycle)
//   - clog2()     : ceiling log2, used to size the beat counter
package ddr_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // One word leaves the chip in WIDTH/2 clock cycles.
  function automatic int beats(input int width);
    return width / 2;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ser_ddr_mux.sv
// ser_ddr_mux
//   Clock-phase output multiplexer of the DDR serializer, kept in its own
//   module so it can be constrained on its own or replaced by a hard cell.
// Ports:
//   clk        in  : serializer clock; its level selects the emitted bit
//   en         in  : serializer is emitting a word
//   e0         in  : bit presented while clk is high
//   e1         in  : bit presented while clk is low
//   serial_out out : DDR serial data, forced to 0 when en is low
module ser_ddr_mux (
  input  logic clk,
  input  logic en,
  input  logic e0,
  input  logic e1,
  output logic serial_out
);

  // Intentionally clock-gated: a single balanced mux on the clock level.
  assign serial_out = en & (clk ? e0 : e1);

endmodule

// File: rtl/ddr_tree_serializer.sv
// ddr_tree_serializer
//   WIDTH:1 double-data-rate serializer. A parallel word enters a one-word
//   holding buffer through a valid/ready handshake; the shifter takes it
//   from the buffer and emits two bits per clock (high phase, low phase).
//   A word waiting in the buffer at the last beat is reloaded directly, so
//   consecutive words stream without a gap.
// Parameters:
//   WIDTH      : word width, power of 2, >= 4
//   MSB_FIRST  : 0 = bit 0 leaves first, 1 = bit WIDTH-1 leaves first
// Ports:
//   clk        in  : sole clock, both phases carry data
//   rst        in  : asynchronous active-high reset
//   par_in     in  : parallel word, taken when par_valid && par_ready
//   par_valid  in  : par_in holds a word
//   par_ready  out : holding buffer empty (register-derived only)
//   serial_out out : DDR serial data, 0 when idle
//   ser_active out : shifter is emitting a word
//   ser_frame  out : first cycle of each emitted word
module ddr_tree_serializer
  import ddr_ser_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             serial_out,
  output logic             ser_active,
  output logic             ser_frame
);

  localparam int BEATS = beats(WIDTH);
  localparam int CNT_W = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] shreg_shifted;
  logic             e0;
  logic             e1;

  // The emit end of the shifter depends on bit order; the register always
  // moves by two toward that end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign e0            = shreg_q[WIDTH-1];
      assign e1            = shreg_q[WIDTH-2];
      assign shreg_shifted = {shreg_q[WIDTH-3:0], 2'b00};
    end else begin : g_lsb_first
      assign e0            = shreg_q[0];
      assign e1            = shreg_q[1];
      assign shreg_shifted = {2'b00, shreg_q[WIDTH-1:2]};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;

    // Accept only into an empty buffer; the transfers below only fire when
    // it is full, so the two never touch buf_full in the same cycle.
    if (par_valid && !buf_full_q) begin
      buf_d      = par_in;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          shreg_d    = buf_q;
          buf_full_d = 1'b0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST_BEAT) begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + 1'b1;
        end else if (buf_full_q) begin
          // Gapless hand-over: next word starts right after the last beat.
          shreg_d    = buf_q;
          buf_full_d = 1'b0;
          cnt_d      = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
    end
  end

  assign par_ready  = !buf_full_q;
  assign ser_active = (state_q == SHIFT);
  assign ser_frame  = (state_q == SHIFT) && (cnt_q == '0);

  ser_ddr_mux u_ddr_mux (
    .clk        (clk),
    .en         (ser_active),
    .e0         (e0),
    .e1         (e1),
    .serial_out (serial_out)
  );

endmodule

// File: tb/tb_ddr_tree_serializer.sv
// tb_ddr_tree_serializer
//   Two serializer instances (WIDTH=16 LSB-first, WIDTH=4 MSB-first) run
//   side by side. For each instance a driver offers words and predicts,
//   from the word-timing rules, the edge each word is accepted and the
//   cycle its first beat appears; it pushes {word, start cycle} into a
//   queue. A monitor samples every clock phase and compares the DUT
//   against the queue head (or against idle when no word is due).
module tb_ddr_tree_serializer;

  typedef struct {
    logic [15:0] word;
    int          start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Edge index: the first rising edge after reset release is edge 0, and
  // "cycle c" is the interval that follows edge c.
  int edge_idx = -1;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_idx <= -1;
    else     edge_idx <= edge_idx + 1;
  end

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  bit go_run   = 1'b0;
  bit go_rst   = 1'b0;
  bit run_done [2];
  bit armed    [2];
  bit fin_done [2];
  int rst_cyc  [2];

  logic ser_out_w [2];
  logic active_w  [2];
  logic frame_w   [2];
  logic ready_w   [2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, edge_idx);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int W     = (gi == 0) ? 16 : 4;
    localparam bit MSB   = (gi == 0) ? 1'b0 : 1'b1;
    localparam int BEATS = W / 2;

    logic [W-1:0] par_in    = '0;
    logic         par_valid = 1'b0;
    exp_t         q[$];

    ddr_tree_serializer #(.WIDTH(W), .MSB_FIRST(MSB)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .par_in     (par_in),
      .par_valid  (par_valid),
      .par_ready  (ready_w[gi]),
      .serial_out (ser_out_w[gi]),
      .ser_active (active_w[gi]),
      .ser_frame  (frame_w[gi])
    );

    // Driver + timing model.
    // Accept edge a = max(next edge, previous transfer edge + 1): the buffer
    // frees up one edge after its word moves into the shifter.
    // Start cycle s = max(a + 1, previous start + BEATS).
    initial begin
      logic [15:0] words[$];
      int          gaps[$];
      int          s_prev;
      int          a;
      int          s;
      int          first_start;
      string       pfx;
      pfx    = $sformatf("w%0d", W);
      s_prev = -1000;
      for (int ph = 0; ph < 3; ph++) begin
        words.delete();
        gaps.delete();
        case (ph)
          0: begin
            wait (go_run);
            words = '{16'hA5C3, 16'hFFFF, 16'h0000, 16'h1234, 16'h5678, 16'h9ABC, 16'h0006, 16'h0009};
            gaps  = '{0, 12, 0, 12, 0, 0, 12, 0};
            for (int k = 0; k < 40; k++) begin
              words.push_back(16'($urandom));
              gaps.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * BEATS)) : 0);
            end
          end
          1: begin
            wait (go_rst);
            words = '{16'hA5C3, 16'($urandom)};
            gaps  = '{0, 0};
          end
          default: begin
            for (int k = 0; k < 12; k++) begin
              words.push_back(16'($urandom));
              gaps.push_back((k == 0) ? 0 : int'($urandom_range(0, BEATS)));
            end
          end
        endcase
        first_start = 0;
        for (int k = 0; k < words.size(); k++) begin
          for (int g = 0; g < gaps[k]; g++) begin
            par_valid = 1'b0;
            par_in    = W'($urandom);
            @(posedge clk); #1;
          end
          par_valid = 1'b1;
          par_in    = words[k][W-1:0];
          a = ((edge_idx + 1) > (s_prev + 1)) ? (edge_idx + 1) : (s_prev + 1);
          while (edge_idx + 1 < a) begin
            chk({pfx, "_ready_low"}, ready_w[gi], 0);
            @(posedge clk); #1;
          end
          chk({pfx, "_ready_high"}, ready_w[gi], 1);
          @(posedge clk); #1;
          s = ((a + 1) > (s_prev + BEATS)) ? (a + 1) : (s_prev + BEATS);
          q.push_back('{words[k], s});
          if (k == 0) first_start = s;
          s_prev    = s;
          par_valid = 1'b0;
          par_in    = W'($urandom);
        end
        case (ph)
          0: run_done[gi] = 1'b1;
          1: begin
            // Reset lands in cycle 4 of the first word, second word buffered.
            rst_cyc[gi] = first_start + 3;
            armed[gi]   = 1'b1;
            wait (rst);
            par_valid = 1'b0;
            q.delete();
            s_prev = -1000;
            wait (!rst);
          end
          default: fin_done[gi] = 1'b1;
        endcase
      end
    end

    // Monitor: one comparison set per clock phase.
    initial begin
      int          c;
      int          b;
      int          p0;
      int          p1;
      logic [15:0] w;
      string       pfx;
      pfx = $sformatf("w%0d", W);
      forever begin
        @(posedge clk); #2;
        if (mon_en && !rst) begin
          c = edge_idx;
          while (q.size() > 0 && c >= q[0].start + BEATS) void'(q.pop_front());
          if (q.size() > 0 && c >= q[0].start) begin
            b  = c - q[0].start;
            w  = q[0].word;
            p0 = MSB ? (W - 1 - 2 * b) : (2 * b);
            p1 = MSB ? (W - 2 - 2 * b) : (2 * b + 1);
            chk({pfx, "_active"}, active_w[gi], 1);
            chk({pfx, "_frame"}, frame_w[gi], (b == 0) ? 1 : 0);
            chk({pfx, "_bit_hi"}, ser_out_w[gi], w[p0]);
            @(negedge clk); #2;
            if (mon_en && !rst) chk({pfx, "_bit_lo"}, ser_out_w[gi], w[p1]);
            if (b == BEATS - 1 && q.size() > 0) void'(q.pop_front());
          end else begin
            chk({pfx, "_idle_active"}, active_w[gi], 0);
            chk({pfx, "_idle_frame"}, frame_w[gi], 0);
            chk({pfx, "_idle_hi"}, ser_out_w[gi], 0);
            @(negedge clk); #2;
            if (mon_en && !rst) chk({pfx, "_idle_lo"}, ser_out_w[gi], 0);
          end
        end
      end
    end
  end

  // Sequencer: reset, idle window, streaming run, mid-word reset, restart.
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d_reset_ready", i), ready_w[i], 1);
      chk($sformatf("dut%0d_reset_active", i), active_w[i], 0);
      chk($sformatf("dut%0d_reset_frame", i), frame_w[i], 0);
      chk($sformatf("dut%0d_reset_serial", i), ser_out_w[i], 0);
    end
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    go_run = 1'b1;
    wait (run_done[0] && run_done[1]);
    repeat (30) @(posedge clk);
    #1;
    go_rst = 1'b1;
    wait (armed[0] && armed[1]);
    n = 0;
    while (edge_idx != rst_cyc[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_align_bound", (n < 100) ? 1 : 0, 1);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d_async_rst_serial", i), ser_out_w[i], 0);
      chk($sformatf("dut%0d_async_rst_active", i), active_w[i], 0);
      chk($sformatf("dut%0d_async_rst_frame", i), frame_w[i], 0);
      chk($sformatf("dut%0d_async_rst_ready", i), ready_w[i], 1);
    end
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    wait (fin_done[0] && fin_done[1]);
    repeat (30) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
    $fatal(1, "watchdog expired");
  end

endmodule
